// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the CPU datapath.
//
// Steps the datapath through fetch (T0-T2) and a per-opcode execute sequence
// (T3-T7) decoded from ir[31:27]. Memory steps (fetch T1, ld T6, st T7) hold
// their strobes until mem_ready; MAX_WAIT consecutive not-ready cycles raise
// the sticky mem_err and halt. Undefined opcodes raise the sticky illegal flag.
//
// Optional build macro: SINGLE_STEP_EN
//   defined   - adds input 'step'; after each instruction the unit parks in
//               PAUSE (t_step=14, strobes 0) until a cycle with step=1.
//   undefined - no 'step' port; each instruction is followed directly by T0.
//
// Ports:
//   clock      in   system clock, rising edge
//   clear      in   synchronous active-high reset
//   ir         in   instruction register, opcode = ir[31:27]
//   con_ff     in   branch condition flip-flop
//   mem_ready  in   RAM access complete this cycle
//   step       in   (SINGLE_STEP_EN only) release from PAUSE
//   <strobes>  out  datapath control strobes and ALU op selects
//   run        out  1 while not halted
//   illegal    out  sticky undefined-opcode flag
//   mem_err    out  sticky memory-timeout flag
//   t_step     out  current step 0-7, 14 paused, 15 halted
module control_sequencer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        mem_ready,
`ifdef SINGLE_STEP_EN
    input  logic        step,
`endif
    output logic        PCin,
    output logic        PCout,
    output logic        IncPC,
    output logic        MARin,
    output logic        MDRin,
    output logic        MDRout,
    output logic        MDMuxread,
    output logic        RAMread,
    output logic        RAMwrite,
    output logic        IRin,
    output logic        Yin,
    output logic        Zlowin,
    output logic        Zhighin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        BAout,
    output logic        CSEout,
    output logic        CONin,
    output logic        InPortout,
    output logic        OutPortin,
    output logic        ADD,
    output logic        SUB,
    output logic        MUL,
    output logic        DIV,
    output logic        AND,
    output logic        OR,
    output logic        SHR,
    output logic        SHRA,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        run,
    output logic        illegal,
    output logic        mem_err,
    output logic [3:0]  t_step
);

    typedef enum logic [3:0] {
        StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StPause, StHalted
    } state_e;

    typedef enum logic [3:0] {
        ClsRegAlu, ClsMulDiv, ClsUnary, ClsImm, ClsLdi, ClsLd, ClsSt, ClsBr,
        ClsJr, ClsIn, ClsOut, ClsMfhi, ClsMflo, ClsNop, ClsHalt, ClsIllegal
    } cls_e;

    // One-hot ALU select positions.
    localparam int unsigned AluAdd  = 0;
    localparam int unsigned AluSub  = 1;
    localparam int unsigned AluMul  = 2;
    localparam int unsigned AluDiv  = 3;
    localparam int unsigned AluAnd  = 4;
    localparam int unsigned AluOr   = 5;
    localparam int unsigned AluShr  = 6;
    localparam int unsigned AluShra = 7;
    localparam int unsigned AluShl  = 8;
    localparam int unsigned AluRor  = 9;
    localparam int unsigned AluRol  = 10;
    localparam int unsigned AluNeg  = 11;
    localparam int unsigned AluNot  = 12;

    localparam logic [7:0] WaitLimit = 8'(MAX_WAIT - 1);

`ifdef SINGLE_STEP_EN
    localparam state_e EndState = StPause;
`else
    localparam state_e EndState = StT0;
`endif

    state_e      state_q, state_d;
    logic [7:0]  wait_q, wait_d;
    logic        illegal_q, illegal_d;
    logic        mem_err_q, mem_err_d;
    // High for the cycle registered while clear was asserted: T0 stays quiet
    // then, and fetch begins on the first cycle after clear drops.
    logic        rst_q;

    cls_e        cls;
    logic [12:0] alu_sel;
    logic        alu_en;

    logic        unused_ir;
    assign unused_ir = ^ir[26:0];

    // Opcode decode: instruction class plus the ALU op it would use.
    always_comb begin
        cls     = ClsIllegal;
        alu_sel = '0;
        case (ir[31:27])
            5'b00000: begin cls = ClsLd;     alu_sel[AluAdd]  = 1'b1; end
            5'b00001: begin cls = ClsLdi;    alu_sel[AluAdd]  = 1'b1; end
            5'b00010: begin cls = ClsSt;     alu_sel[AluAdd]  = 1'b1; end
            5'b00011: begin cls = ClsRegAlu; alu_sel[AluAdd]  = 1'b1; end
            5'b00100: begin cls = ClsRegAlu; alu_sel[AluSub]  = 1'b1; end
            5'b00101: begin cls = ClsRegAlu; alu_sel[AluAnd]  = 1'b1; end
            5'b00110: begin cls = ClsRegAlu; alu_sel[AluOr]   = 1'b1; end
            5'b00111: begin cls = ClsRegAlu; alu_sel[AluRor]  = 1'b1; end
            5'b01000: begin cls = ClsRegAlu; alu_sel[AluRol]  = 1'b1; end
            5'b01001: begin cls = ClsRegAlu; alu_sel[AluShr]  = 1'b1; end
            5'b01010: begin cls = ClsRegAlu; alu_sel[AluShra] = 1'b1; end
            5'b01011: begin cls = ClsRegAlu; alu_sel[AluShl]  = 1'b1; end
            5'b01100: begin cls = ClsImm;    alu_sel[AluAdd]  = 1'b1; end
            5'b01101: begin cls = ClsImm;    alu_sel[AluAnd]  = 1'b1; end
            5'b01110: begin cls = ClsImm;    alu_sel[AluOr]   = 1'b1; end
            5'b01111: begin cls = ClsMulDiv; alu_sel[AluDiv]  = 1'b1; end
            5'b10000: begin cls = ClsMulDiv; alu_sel[AluMul]  = 1'b1; end
            5'b10001: begin cls = ClsUnary;  alu_sel[AluNeg]  = 1'b1; end
            5'b10010: begin cls = ClsUnary;  alu_sel[AluNot]  = 1'b1; end
            5'b10011: begin cls = ClsBr;     alu_sel[AluAdd]  = 1'b1; end
            5'b10100: cls = ClsJr;
            5'b10110: cls = ClsIn;
            5'b10111: cls = ClsOut;
            5'b11000: cls = ClsMfhi;
            5'b11001: cls = ClsMflo;
            5'b11010: cls = ClsNop;
            5'b11011: cls = ClsHalt;
            default:  cls = ClsIllegal;
        endcase
    end

    // Next-state: pick the following step, then apply the memory stall rule.
    always_comb begin
        state_e step_next;
        logic   last_step;
        logic   mem_step;

        state_d   = state_q;
        wait_d    = wait_q;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        step_next = state_q;
        last_step = 1'b0;
        mem_step  = 1'b0;

        case (state_q)
            StT0: step_next = StT1;
            StT1: begin
                mem_step  = 1'b1;
                step_next = StT2;
            end
            StT2: begin
                step_next = StT3;
                case (cls)
                    ClsNop:     last_step = 1'b1;
                    ClsIllegal: begin
                        last_step = 1'b1;
                        illegal_d = 1'b1;
                    end
                    ClsHalt:    step_next = StHalted;
                    default:    ;
                endcase
            end
            StT3: begin
                step_next = StT4;
                last_step = (cls == ClsJr) || (cls == ClsIn) || (cls == ClsOut) ||
                            (cls == ClsMfhi) || (cls == ClsMflo);
            end
            StT4: begin
                step_next = StT5;
                last_step = (cls == ClsUnary);
            end
            StT5: begin
                step_next = StT6;
                last_step = (cls == ClsRegAlu) || (cls == ClsImm) || (cls == ClsLdi);
            end
            StT6: begin
                step_next = StT7;
                mem_step  = (cls == ClsLd);
                last_step = (cls == ClsMulDiv) || (cls == ClsBr);
            end
            StT7: begin
                mem_step  = (cls == ClsSt);
                last_step = 1'b1;
            end
`ifdef SINGLE_STEP_EN
            StPause:  step_next = step ? StT0 : StPause;
`else
            StPause:  step_next = StT0;
`endif
            StHalted: step_next = StHalted;
            default:  step_next = StT0;
        endcase

        if (rst_q) begin
            state_d = StT0;
            wait_d  = '0;
        end else if (mem_step && !mem_ready) begin
            if (wait_q == WaitLimit) begin
                mem_err_d = 1'b1;
                state_d   = StHalted;
                wait_d    = '0;
            end else begin
                wait_d = wait_q + 8'd1;
            end
        end else begin
            wait_d  = '0;
            state_d = last_step ? EndState : step_next;
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q   <= StT0;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
            rst_q     <= 1'b1;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
            rst_q     <= 1'b0;
        end
    end

    // Moore outputs from the registered step and ir.
    always_comb begin
        PCin = 1'b0;  PCout = 1'b0;   IncPC = 1'b0;    MARin = 1'b0;  MDRin = 1'b0;
        MDRout = 1'b0; MDMuxread = 1'b0; RAMread = 1'b0; RAMwrite = 1'b0; IRin = 1'b0;
        Yin = 1'b0;   Zlowin = 1'b0;  Zhighin = 1'b0;  Zlowout = 1'b0; Zhighout = 1'b0;
        HIin = 1'b0;  LOin = 1'b0;    HIout = 1'b0;    LOout = 1'b0;
        Gra = 1'b0;   Grb = 1'b0;     Grc = 1'b0;      Rin = 1'b0;    Rout = 1'b0;
        BAout = 1'b0; CSEout = 1'b0;  CONin = 1'b0;    InPortout = 1'b0; OutPortin = 1'b0;
        alu_en = 1'b0;
        t_step = 4'd0;

        case (state_q)
            StT0: begin
                t_step = 4'd0;
                if (!rst_q) begin
                    PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zlowin = 1'b1;
                end
            end
            StT1: begin
                t_step = 4'd1;
                Zlowout = 1'b1; PCin = 1'b1; MDMuxread = 1'b1; RAMread = 1'b1; MDRin = 1'b1;
            end
            StT2: begin
                t_step = 4'd2;
                MDRout = 1'b1; IRin = 1'b1;
            end
            StT3: begin
                t_step = 4'd3;
                case (cls)
                    ClsRegAlu, ClsImm: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    ClsLdi, ClsLd, ClsSt: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
                    ClsMulDiv: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                    ClsUnary: begin Grb = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zlowin = 1'b1; end
                    ClsBr:    begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    ClsJr:    begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    ClsIn:    begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    ClsOut:   begin Gra = 1'b1; Rout = 1'b1; OutPortin = 1'b1; end
                    ClsMfhi:  begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    ClsMflo:  begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default:  ;
                endcase
            end
            StT4: begin
                t_step = 4'd4;
                case (cls)
                    ClsRegAlu: begin Grc = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zlowin = 1'b1; end
                    ClsMulDiv: begin
                        Grb = 1'b1; Rout = 1'b1; alu_en = 1'b1; Zlowin = 1'b1; Zhighin = 1'b1;
                    end
                    ClsUnary: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    ClsImm, ClsLdi, ClsLd, ClsSt: begin
                        CSEout = 1'b1; alu_en = 1'b1; Zlowin = 1'b1;
                    end
                    ClsBr:    begin PCout = 1'b1; Yin = 1'b1; end
                    default:  ;
                endcase
            end
            StT5: begin
                t_step = 4'd5;
                case (cls)
                    ClsRegAlu, ClsImm, ClsLdi: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    ClsMulDiv: begin Zlowout = 1'b1; LOin = 1'b1; end
                    ClsLd, ClsSt: begin Zlowout = 1'b1; MARin = 1'b1; end
                    ClsBr:    begin CSEout = 1'b1; alu_en = 1'b1; Zlowin = 1'b1; end
                    default:  ;
                endcase
            end
            StT6: begin
                t_step = 4'd6;
                case (cls)
                    ClsMulDiv: begin Zhighout = 1'b1; HIin = 1'b1; end
                    ClsLd:    begin MDMuxread = 1'b1; RAMread = 1'b1; MDRin = 1'b1; end
                    // Store data comes from the register file, not RAM.
                    ClsSt:    begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
                    ClsBr:    begin Zlowout = 1'b1; PCin = con_ff; end
                    default:  ;
                endcase
            end
            StT7: begin
                t_step = 4'd7;
                case (cls)
                    ClsLd:    begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    ClsSt:    RAMwrite = 1'b1;
                    default:  ;
                endcase
            end
            StPause:  t_step = 4'd14;
            StHalted: t_step = 4'd15;
            default:  t_step = 4'd0;
        endcase
    end

    // alu_sel is one-hot by construction, so at most one op strobe is high.
    always_comb begin
        ADD  = alu_en & alu_sel[AluAdd];
        SUB  = alu_en & alu_sel[AluSub];
        MUL  = alu_en & alu_sel[AluMul];
        DIV  = alu_en & alu_sel[AluDiv];
        AND  = alu_en & alu_sel[AluAnd];
        OR   = alu_en & alu_sel[AluOr];
        SHR  = alu_en & alu_sel[AluShr];
        SHRA = alu_en & alu_sel[AluShra];
        SHL  = alu_en & alu_sel[AluShl];
        ROR  = alu_en & alu_sel[AluRor];
        ROL  = alu_en & alu_sel[AluRol];
        NEG  = alu_en & alu_sel[AluNeg];
        NOT  = alu_en & alu_sel[AluNot];
    end

    assign run     = (state_q != StHalted);
    assign illegal = illegal_q;
    assign mem_err = mem_err_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a step-list model of each instruction is checked
// against the DUT on every falling edge, plus hand-computed literal checks.
module tb_control_sequencer;

    localparam int unsigned MaxWait = 15;

    logic        clock = 1'b0;
    logic        clear, con_ff, mem_ready;
    logic [31:0] ir;
    logic PCin, PCout, IncPC, MARin, MDRin, MDRout, MDMuxread, RAMread, RAMwrite, IRin;
    logic Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, HIout, LOout;
    logic Gra, Grb, Grc, Rin, Rout, BAout, CSEout, CONin, InPortout, OutPortin;
    logic ADD, SUB, MUL, DIV, AND, OR, SHR, SHRA, SHL, ROR, ROL, NEG, NOT;
    logic run, illegal, mem_err;
    logic [3:0] t_step;

    always #5 clock = ~clock;

    control_sequencer #(.MAX_WAIT(MaxWait)) dut (
        .clock(clock), .clear(clear), .ir(ir), .con_ff(con_ff), .mem_ready(mem_ready),
        .PCin(PCin), .PCout(PCout), .IncPC(IncPC), .MARin(MARin), .MDRin(MDRin),
        .MDRout(MDRout), .MDMuxread(MDMuxread), .RAMread(RAMread), .RAMwrite(RAMwrite),
        .IRin(IRin), .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
        .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
        .CSEout(CSEout), .CONin(CONin), .InPortout(InPortout), .OutPortin(OutPortin),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .AND(AND), .OR(OR), .SHR(SHR),
        .SHRA(SHRA), .SHL(SHL), .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT),
        .run(run), .illegal(illegal), .mem_err(mem_err), .t_step(t_step)
    );

    logic [41:0] act;
    logic [6:0]  sts;
    assign act = {NOT, NEG, ROL, ROR, SHL, SHRA, SHR, OR, AND, DIV, MUL, SUB, ADD,
                  OutPortin, InPortout, CONin, CSEout, BAout, Rout, Rin, Grc, Grb, Gra,
                  LOout, HIout, LOin, HIin, Zhighout, Zlowout, Zhighin, Zlowin, Yin,
                  IRin, RAMwrite, RAMread, MDMuxread, MDRout, MDRin, MARin, IncPC, PCout, PCin};
    assign sts = {run, illegal, mem_err, t_step};

    localparam logic [41:0] SPcin = 42'd1 << 0,  SPcout = 42'd1 << 1,  SIncPc = 42'd1 << 2;
    localparam logic [41:0] SMarin = 42'd1 << 3, SMdrin = 42'd1 << 4,  SMdrout = 42'd1 << 5;
    localparam logic [41:0] SMdMux = 42'd1 << 6, SRamRd = 42'd1 << 7,  SRamWr = 42'd1 << 8;
    localparam logic [41:0] SIrin = 42'd1 << 9,  SYin = 42'd1 << 10,   SZlowin = 42'd1 << 11;
    localparam logic [41:0] SZhighin = 42'd1 << 12, SZlowout = 42'd1 << 13;
    localparam logic [41:0] SZhighout = 42'd1 << 14, SHiin = 42'd1 << 15, SLoin = 42'd1 << 16;
    localparam logic [41:0] SHiout = 42'd1 << 17, SLoout = 42'd1 << 18, SGra = 42'd1 << 19;
    localparam logic [41:0] SGrb = 42'd1 << 20,  SGrc = 42'd1 << 21,   SRin = 42'd1 << 22;
    localparam logic [41:0] SRout = 42'd1 << 23, SBaout = 42'd1 << 24, SCseout = 42'd1 << 25;
    localparam logic [41:0] SConin = 42'd1 << 26, SInPort = 42'd1 << 27, SOutPort = 42'd1 << 28;
    localparam logic [41:0] SAdd = 42'd1 << 29,  SSub = 42'd1 << 30,   SMul = 42'd1 << 31;
    localparam logic [41:0] SDiv = 42'd1 << 32,  SAnd = 42'd1 << 33,   SOr = 42'd1 << 34;
    localparam logic [41:0] SShr = 42'd1 << 35,  SShra = 42'd1 << 36,  SShl = 42'd1 << 37;
    localparam logic [41:0] SRor = 42'd1 << 38,  SRol = 42'd1 << 39,   SNeg = 42'd1 << 40;
    localparam logic [41:0] SNot = 42'd1 << 41;
    localparam logic [41:0] AluMask = 42'h3FFE0000000;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each instruction is a list of expected control words, one per step.
    typedef struct packed {
        logic [41:0] w;
        logic        mem;      // memory step: held while mem_ready=0
        logic        cond_pc;  // PCin added when con_ff=1
    } ent_t;

    ent_t prog[$];
    int   pos = 0;
    int   waits = 0;
    bit   m_halted = 0, m_illegal = 0, m_err = 0, m_quiet = 0;
    bit   model_on = 0;

    function automatic void add(input logic [41:0] w, input logic mem = 1'b0,
                                input logic cpc = 1'b0);
        ent_t e;
        e.w = w;
        e.mem = mem;
        e.cond_pc = cpc;
        prog.push_back(e);
    endfunction

    function automatic void new_fetch();
        prog.delete();
        add(SPcout | SMarin | SIncPc | SZlowin);
        add(SZlowout | SPcin | SMdMux | SRamRd | SMdrin, 1'b1);
        add(SMdrout | SIrin);
        pos = 0;
    endfunction

    function automatic logic [41:0] alu_of(input logic [4:0] op);
        case (op)
            5'd3, 5'd12: return SAdd;
            5'd4:        return SSub;
            5'd5, 5'd13: return SAnd;
            5'd6, 5'd14: return SOr;
            5'd7:        return SRor;
            5'd8:        return SRol;
            5'd9:        return SShr;
            5'd10:       return SShra;
            5'd11:       return SShl;
            5'd15:       return SDiv;
            5'd16:       return SMul;
            5'd17:       return SNeg;
            5'd18:       return SNot;
            default:     return '0;
        endcase
    endfunction

    function automatic void decode(input logic [4:0] op);
        logic [41:0] a;
        a = alu_of(op);
        case (op)
            5'd0: begin
                add(SGrb | SBaout | SYin); add(SCseout | SAdd | SZlowin);
                add(SZlowout | SMarin); add(SMdMux | SRamRd | SMdrin, 1'b1);
                add(SMdrout | SGra | SRin);
            end
            5'd1: begin
                add(SGrb | SBaout | SYin); add(SCseout | SAdd | SZlowin);
                add(SZlowout | SGra | SRin);
            end
            5'd2: begin
                add(SGrb | SBaout | SYin); add(SCseout | SAdd | SZlowin);
                add(SZlowout | SMarin); add(SGra | SRout | SMdrin); add(SRamWr, 1'b1);
            end
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11: begin
                add(SGrb | SRout | SYin); add(SGrc | SRout | a | SZlowin);
                add(SZlowout | SGra | SRin);
            end
            5'd12, 5'd13, 5'd14: begin
                add(SGrb | SRout | SYin); add(SCseout | a | SZlowin);
                add(SZlowout | SGra | SRin);
            end
            5'd15, 5'd16: begin
                add(SGra | SRout | SYin); add(SGrb | SRout | a | SZlowin | SZhighin);
                add(SZlowout | SLoin); add(SZhighout | SHiin);
            end
            5'd17, 5'd18: begin
                add(SGrb | SRout | a | SZlowin); add(SZlowout | SGra | SRin);
            end
            5'd19: begin
                add(SGra | SRout | SConin); add(SPcout | SYin);
                add(SCseout | SAdd | SZlowin); add(SZlowout, 1'b0, 1'b1);
            end
            5'd20: add(SGra | SRout | SPcin);
            5'd22: add(SInPort | SGra | SRin);
            5'd23: add(SGra | SRout | SOutPort);
            5'd24: add(SHiout | SGra | SRin);
            5'd25: add(SLoout | SGra | SRin);
            5'd26: new_fetch();
            5'd27: m_halted = 1'b1;
            default: begin
                m_illegal = 1'b1;
                new_fetch();
            end
        endcase
        if (prog.size() > 3) pos = 3;
    endfunction

    // Compare on the falling edge, then advance the model with the inputs the
    // DUT will sample at the next rising edge.
    initial begin
        forever begin
            logic [41:0] exp_w;
            logic [6:0]  exp_s;
            @(negedge clock);
            if (model_on) begin
                if (m_halted || m_quiet) begin
                    exp_w = '0;
                end else begin
                    exp_w = prog[pos].w;
                    if (prog[pos].cond_pc && con_ff) exp_w = exp_w | SPcin;
                end
                exp_s = {~m_halted, m_illegal, m_err,
                         m_halted ? 4'd15 : (m_quiet ? 4'd0 : 4'(pos))};
                check("model_strobes", 64'(act), 64'(exp_w));
                check("model_status", 64'(sts), 64'(exp_s));
                check("one_alu_op", 64'($countones(act & AluMask) <= 1), 64'd1);

                if (clear) begin
                    m_halted = 0; m_illegal = 0; m_err = 0; waits = 0; m_quiet = 1;
                    new_fetch();
                end else if (m_quiet) begin
                    m_quiet = 0;
                end else if (!m_halted) begin
                    if (prog[pos].mem && !mem_ready) begin
                        waits++;
                        if (waits == MaxWait) begin
                            m_halted = 1;
                            m_err = 1;
                        end
                    end else begin
                        waits = 0;
                        if (pos == 2) decode(ir[31:27]);
                        else if (pos == prog.size() - 1) new_fetch();
                        else pos++;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    typedef struct packed {
        logic [31:0] instr;
        int          len;
    } vec_t;

    vec_t table_v[22];

    initial begin
        table_v = '{
            '{32'h80000000, 7}, '{32'h78000000, 7}, '{32'h88000000, 5}, '{32'h90000000, 5},
            '{32'h10000000, 8}, '{32'h18000000, 6}, '{32'h20000000, 6}, '{32'h28000000, 6},
            '{32'h30000000, 6}, '{32'h38000000, 6}, '{32'h40000000, 6}, '{32'h48000000, 6},
            '{32'h50000000, 6}, '{32'h58000000, 6}, '{32'h60000000, 6}, '{32'h68000000, 6},
            '{32'hA0000000, 4}, '{32'hB0000000, 4}, '{32'hB8000000, 4}, '{32'hC0000000, 4},
            '{32'hC8000000, 4}, '{32'hD0000000, 3}
        };
        clear = 1'b1; ir = 32'h0A00FF00; con_ff = 1'b0; mem_ready = 1'b1;
        cyc(2);
        // Reset state: quiet T0, run=1, flags clear.
        check("reset_status", 64'(sts), 64'(7'b1000000));
        check("reset_strobes", 64'(act), 64'd0);
        m_quiet = 1; new_fetch(); model_on = 1;
        clear = 1'b0;
        cyc();

        // ldi R4,0xFF00
        check("ldi_t0", 64'(act), 64'(SPcout | SMarin | SIncPc | SZlowin));
        cyc(3);
        check("ldi_t3", 64'(act), 64'(SGrb | SBaout | SYin));
        check("ldi_t3_step", 64'(t_step), 64'd3);
        cyc(2);
        check("ldi_t5", 64'(act), 64'(SZlowout | SGra | SRin));
        cyc();
        check("ldi_back_t0", 64'(t_step), 64'd0);

        // ori R3,R4,0x53
        ir = 32'h71A00053;
        cyc(4);
        check("ori_t4", 64'(act), 64'(SCseout | SOr | SZlowin));
        cyc();
        check("ori_t5_no_op", 64'(act & AluMask), 64'd0);
        cyc();

        // ld with three not-ready cycles at T6
        ir = 32'h00800010;
        cyc(6);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) mem_ready = 1'b1;
            check("ld_t6_held", 64'({t_step, act}), 64'({4'd6, SMdMux | SRamRd | SMdrin}));
            cyc();
        end
        check("ld_t7", 64'({t_step, act}), 64'({4'd7, SMdrout | SGra | SRin}));
        cyc();

        // br, condition false then true
        ir = 32'h98000008;
        cyc(6);
        check("br_t6_nt", 64'(act), 64'(SZlowout));
        cyc();
        con_ff = 1'b1;
        cyc(6);
        check("br_t6_taken", 64'(act), 64'(SZlowout | SPcin));
        cyc();
        con_ff = 1'b0;

        // Remaining opcodes, checked by the model only
        for (int i = 0; i < 22; i++) begin
            ir = table_v[i].instr;
            cyc(table_v[i].len);
        end

        // Memory timeout in fetch T1
        ir = 32'h18000000;
        mem_ready = 1'b0;
        cyc(15);
        check("stall_t1_last", 64'(sts), 64'(7'b1000001));
        cyc();
        check("timeout_status", 64'(sts), 64'({1'b0, 1'b0, 1'b1, 4'd15}));
        check("timeout_strobes", 64'(act), 64'd0);
        clear = 1'b1;
        mem_ready = 1'b1;
        cyc();
        check("clear_status", 64'(sts), 64'(7'b1000000));
        clear = 1'b0;
        cyc();

        // Illegal opcode, then halt
        ir = 32'hF8000000;
        cyc(2);
        check("illegal_t2", 64'(sts), 64'(7'b1000010));
        cyc();
        check("illegal_set", 64'(sts), 64'(7'b1100000));
        ir = 32'hD8000000;
        cyc(3);
        for (int i = 0; i < 20; i++) begin
            check("halted", 64'({run, act}), 64'd0);
            cyc();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
